// File: rtl/xor_stream_unit.sv
// Registered bitwise XOR/XNOR stream stage with valid/ready flow control and a
// per-burst running XOR accumulator plus 1-based beat counter.

module xor_stream_lane #(
    parameter int INVERT = 0
) (
    input  logic a,
    input  logic b,
    output logic y
);
    localparam logic INV = (INVERT != 0);
    assign y = a ^ b ^ INV;
endmodule

module xor_stream_unit #(
    parameter int WIDTH  = 8,
    parameter int INVERT = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             par,
    output logic             out_last,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            xor_stream_lane #(.INVERT(INVERT)) u_lane (
                .a (a[i]),
                .b (b[i]),
                .y (f[i])
            );
        end
    endgenerate

    // Output slot frees up in the same cycle the consumer drains it.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            par       <= 1'b0;
            out_last  <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state     <= IDLE;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= f;
            par       <= ^f;
            out_last  <= in_last;
            acc       <= acc_reg ^ f;
            beat_cnt  <= cnt_nxt;
            if (in_last) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_reg ^ f;
                cnt_reg <= cnt_nxt;
            end
            case (state)
                IDLE: if (!in_last) begin
                    state <= ACTIVE;
                    busy  <= 1'b1;
                end
                ACTIVE: if (in_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end else if (out_ready) begin
            // Payload registers keep their stale values; only valid drops.
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xor_stream_unit.sv
// Self-checking bench: four parameterisations of xor_stream_unit share one stimulus
// stream; directed tables and sequences plus a randomized run against a burst model.
`timescale 1ns/1ps
module tb_xor_stream_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [7:0] a8, b8;

    always #5 clk = ~clk;

    // WIDTH=1, XOR
    logic       w1_ir, w1_ov, w1_par, w1_last, w1_busy;
    logic [0:0] w1_y, w1_acc;
    logic [7:0] w1_cnt;
    // WIDTH=8, XNOR
    logic       iv_ir, iv_ov, iv_par, iv_last, iv_busy;
    logic [7:0] iv_y, iv_acc, iv_cnt;
    // WIDTH=8, XOR, CNT_W=8 (main)
    logic       m_ir, m_ov, m_par, m_last, m_busy;
    logic [7:0] m_y, m_acc, m_cnt;
    // WIDTH=8, XOR, CNT_W=2
    logic       c2_ir, c2_ov, c2_par, c2_last, c2_busy;
    logic [7:0] c2_y, c2_acc;
    logic [1:0] c2_cnt;

    xor_stream_unit #(.WIDTH(1), .INVERT(0), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w1_ir),
        .a(a8[0:0]), .b(b8[0:0]), .in_last(in_last), .out_valid(w1_ov),
        .out_ready(out_ready), .y(w1_y), .par(w1_par), .out_last(w1_last),
        .acc(w1_acc), .beat_cnt(w1_cnt), .busy(w1_busy));

    xor_stream_unit #(.WIDTH(8), .INVERT(1), .CNT_W(8)) u_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iv_ir),
        .a(a8), .b(b8), .in_last(in_last), .out_valid(iv_ov),
        .out_ready(out_ready), .y(iv_y), .par(iv_par), .out_last(iv_last),
        .acc(iv_acc), .beat_cnt(iv_cnt), .busy(iv_busy));

    xor_stream_unit #(.WIDTH(8), .INVERT(0), .CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_ir),
        .a(a8), .b(b8), .in_last(in_last), .out_valid(m_ov),
        .out_ready(out_ready), .y(m_y), .par(m_par), .out_last(m_last),
        .acc(m_acc), .beat_cnt(m_cnt), .busy(m_busy));

    xor_stream_unit #(.WIDTH(8), .INVERT(0), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_ir),
        .a(a8), .b(b8), .in_last(in_last), .out_valid(c2_ov),
        .out_ready(out_ready), .y(c2_y), .par(c2_par), .out_last(c2_last),
        .acc(c2_acc), .beat_cnt(c2_cnt), .busy(c2_busy));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic l, input logic r);
        in_valid = v; a8 = av; b8 = bv; in_last = l; out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       last;
        logic [7:0] y, acc, cnt;
        logic       olast, busy;
    } vec_t;

    vec_t t1[4];
    vec_t t5[5];

    // Burst-level reference model state for the random run
    logic       md_valid, md_last, md_par, md_busy;
    logic [7:0] md_y, md_acc, md_cnt;
    logic [7:0] burst_acc;
    int         burst_len;

    initial begin
        t1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 8'h0, 8'd1, 1'b0, 1'b1};
        t1[1] = '{8'h0, 8'h1, 1'b0, 8'h1, 8'h1, 8'd2, 1'b0, 1'b1};
        t1[2] = '{8'h1, 8'h0, 1'b0, 8'h1, 8'h0, 8'd3, 1'b0, 1'b1};
        t1[3] = '{8'h1, 8'h1, 1'b1, 8'h0, 8'h0, 8'd4, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++)
            t5[i] = '{8'hFF, 8'h00, (i == 4), 8'hFF, (i % 2 == 0) ? 8'hFF : 8'h00,
                      8'((i + 1) % 4), (i == 4), (i != 4)};

        rst_n = 1'b0;
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        tick(); tick();
        chk("rst_out_valid", 32'(m_ov), 32'd0);
        chk("rst_y", 32'(m_y), 32'd0);
        chk("rst_acc", 32'(m_acc), 32'd0);
        chk("rst_cnt", 32'(m_cnt), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_par_last", {30'd0, m_par, m_last}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(m_ir), 32'd1);

        // WIDTH=1 four-beat burst
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t1[i].a, t1[i].b, t1[i].last, 1'b1);
            tick();
            chk($sformatf("w1_valid[%0d]", i), 32'(w1_ov), 32'd1);
            chk($sformatf("w1_y[%0d]", i), 32'(w1_y), 32'(t1[i].y));
            chk($sformatf("w1_acc[%0d]", i), 32'(w1_acc), 32'(t1[i].acc));
            chk($sformatf("w1_cnt[%0d]", i), 32'(w1_cnt), 32'(t1[i].cnt));
            chk($sformatf("w1_last[%0d]", i), 32'(w1_last), 32'(t1[i].olast));
            chk($sformatf("w1_busy[%0d]", i), 32'(w1_busy), 32'(t1[i].busy));
            chk($sformatf("w1_par[%0d]", i), 32'(w1_par), 32'(t1[i].y[0]));
        end
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        tick();
        chk("drain_valid", 32'(w1_ov), 32'd0);

        // XNOR single-beat burst
        drive(1'b1, 8'hA5, 8'h0F, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        chk("inv_y", 32'(iv_y), 32'h55);
        chk("inv_par", 32'(iv_par), 32'd0);
        chk("inv_acc", 32'(iv_acc), 32'h55);
        chk("inv_cnt", 32'(iv_cnt), 32'd1);
        chk("inv_busy", 32'(iv_busy), 32'd0);
        chk("inv_last", 32'(iv_last), 32'd1);
        tick();

        // Backpressure: first beat held while a second waits
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        tick();
        chk("bp_y0", 32'(m_y), 32'h26);
        drive(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_in_ready[%0d]", i), 32'(m_ir), 32'd0);
            tick();
            chk($sformatf("bp_hold_valid[%0d]", i), 32'(m_ov), 32'd1);
            chk($sformatf("bp_hold_y[%0d]", i), 32'(m_y), 32'h26);
            chk($sformatf("bp_hold_cnt[%0d]", i), 32'(m_cnt), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(m_ir), 32'd1);
        tick();
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        chk("bp_next_y", 32'(m_y), 32'h01);
        chk("bp_next_acc", 32'(m_acc), 32'h27);
        chk("bp_next_cnt", 32'(m_cnt), 32'd2);
        chk("bp_next_last", 32'(m_last), 32'd1);
        tick();
        chk("bp_drained", 32'(m_ov), 32'd0);

        // Asynchronous reset mid-burst
        drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h02, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        chk("mid_busy_before", 32'(m_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_ov), 32'd0);
        chk("mid_rst_busy", 32'(m_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 8'h04, 8'h00, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        chk("mid_post_acc", 32'(m_acc), 32'h04);
        chk("mid_post_cnt", 32'(m_cnt), 32'd1);
        chk("mid_post_busy", 32'(m_busy), 32'd0);
        tick();

        // CNT_W=2 wrap over a five-beat burst
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, t5[i].a, t5[i].b, t5[i].last, 1'b1);
            tick();
            chk($sformatf("c2_y[%0d]", i), 32'(c2_y), 32'(t5[i].y));
            chk($sformatf("c2_acc[%0d]", i), 32'(c2_acc), 32'(t5[i].acc));
            chk($sformatf("c2_cnt[%0d]", i), 32'(c2_cnt), 32'(t5[i].cnt));
            chk($sformatf("c2_last[%0d]", i), 32'(c2_last), 32'(t5[i].olast));
            chk($sformatf("c2_busy[%0d]", i), 32'(c2_busy), 32'(t5[i].busy));
        end
        drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        tick();
        chk("c2_drained", 32'(c2_ov), 32'd0);

        // Randomized streaming against the burst model
        md_valid = 1'b0; md_y = '0; md_acc = '0; md_cnt = '0;
        md_last = 1'b0; md_par = 1'b0; md_busy = 1'b0;
        burst_acc = '0; burst_len = 0;
        begin
            int accepted = 0;
            int cycles = 0;
            logic exp_ready, take;
            logic [7:0] ra, rb, fy;
            logic rv, rl, rr;
            while (accepted < 1000 && cycles < 20000) begin
                cycles++;
                rv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 3) != 0);
                rl = ($urandom_range(0, 4) == 0);
                ra = 8'($urandom);
                rb = 8'($urandom);
                if (rv) drive(1'b1, ra, rb, rl, rr);
                else    drive(1'b0, 8'hxx, 8'hxx, rl, rr);
                #1;
                exp_ready = !md_valid || rr;
                if (m_ir !== exp_ready) chk("rnd_in_ready", 32'(m_ir), 32'(exp_ready));
                take = rv && exp_ready;
                tick();
                if (take) begin
                    accepted++;
                    fy = ra ^ rb;
                    burst_len++;
                    burst_acc = burst_acc ^ fy;
                    md_valid = 1'b1;
                    md_y = fy;
                    md_par = ($countones(fy) % 2) == 1;
                    md_acc = burst_acc;
                    md_cnt = 8'(burst_len % 256);
                    md_last = rl;
                    md_busy = !rl;
                    if (rl) begin
                        burst_acc = '0;
                        burst_len = 0;
                    end
                end else if (rr) begin
                    md_valid = 1'b0;
                end
                chk("rnd_valid", 32'(m_ov), 32'(md_valid));
                chk("rnd_busy", 32'(m_busy), 32'(md_busy));
                if (md_valid) begin
                    chk("rnd_y", 32'(m_y), 32'(md_y));
                    chk("rnd_acc", 32'(m_acc), 32'(md_acc));
                    chk("rnd_cnt", 32'(m_cnt), 32'(md_cnt));
                    chk("rnd_par", 32'(m_par), 32'(md_par));
                    chk("rnd_last", 32'(m_last), 32'(md_last));
                    chk("rnd_c2_cnt", 32'(c2_cnt), 32'(md_cnt[1:0]));
                end
            end
            chk("rnd_accepted_in_budget", 32'(accepted), 32'd1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
